// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with configurable data width,
// oversample ratio, stop-bit count and run-time parity mode.
// Rx_in is synchronised through two flops before any decision is made.
// Each bit is sampled once, at its middle, counted from the start edge.
// A completed frame is reported with a one-cycle Dvalid strobe, together
// with the data word and its parity and framing flags.
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Rx_in,
  input  logic [1:0]           parity_mode,
  output logic [DATA_BITS-1:0] Dout,
  output logic                 Dvalid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  // The counter runs modulo OVERSAMPLE from the start edge, so every bit is
  // sampled at the same phase: OVERSAMPLE/2 clocks into its bit period.
  localparam logic [CW-1:0] SAMPLE_AT = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] WRAP_AT   = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [BW-1:0] BIT_ZERO  = BW'(0);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  logic [1:0]           sync_r;
  logic                 rx_s;
  state_t               state_r;
  logic [CW-1:0]        cnt_r;
  logic [CW-1:0]        cnt_next_s;
  logic                 sample_s;
  logic [BW-1:0]        bit_cnt_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 par_en_r;
  logic                 par_odd_r;
  logic                 par_bit_r;
  logic                 ferr_acc_r;

  // Parity error for a received word: even mode flags an odd count of ones
  // across data+parity bit, odd mode flags an even count.
  function automatic logic parity_error(input logic [DATA_BITS-1:0] data,
                                        input logic                 pbit,
                                        input logic                 odd);
    logic x;
    x = (^data) ^ pbit;
    return x ^ odd;
  endfunction

  assign rx_s = sync_r[1];

  // Two-flop synchroniser for the asynchronous serial line, idle high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], Rx_in};
    end
  end

  // Bit-clock next value and the mid-bit sample strobe.
  always_comb begin
    sample_s   = 1'b0;
    cnt_next_s = CNT_ZERO;
    sample_s   = (cnt_r == SAMPLE_AT);
    if (cnt_r == WRAP_AT) begin
      cnt_next_s = CNT_ZERO;
    end else begin
      cnt_next_s = cnt_r + CNT_ONE;
    end
  end

  // Receive FSM: walks the frame, latches the parity mode at the start edge
  // and publishes the word and flags on the final stop-bit sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      cnt_r      <= CNT_ZERO;
      bit_cnt_r  <= BIT_ZERO;
      shift_r    <= {DATA_BITS{1'b0}};
      par_en_r   <= 1'b0;
      par_odd_r  <= 1'b0;
      par_bit_r  <= 1'b0;
      ferr_acc_r <= 1'b0;
      Dout       <= {DATA_BITS{1'b0}};
      Dvalid     <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      Dvalid <= 1'b0;
      case (state_r)
        IDLE: begin
          cnt_r     <= CNT_ZERO;
          bit_cnt_r <= BIT_ZERO;
          if (!rx_s) begin
            state_r    <= START;
            busy       <= 1'b1;
            par_en_r   <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
            par_odd_r  <= (parity_mode == 2'b10);
            ferr_acc_r <= 1'b0;
          end
        end
        START: begin
          cnt_r <= cnt_next_s;
          if (sample_s) begin
            if (rx_s) begin
              // Line went back high before mid start bit: treat as a glitch.
              state_r <= IDLE;
              busy    <= 1'b0;
            end else begin
              state_r   <= DATA;
              bit_cnt_r <= BIT_ZERO;
            end
          end
        end
        DATA: begin
          cnt_r <= cnt_next_s;
          if (sample_s) begin
            shift_r <= {rx_s, shift_r[DATA_BITS-1:1]};
            if (bit_cnt_r == LAST_DATA) begin
              bit_cnt_r <= BIT_ZERO;
              state_r   <= par_en_r ? PARITY : STOP;
            end else begin
              bit_cnt_r <= bit_cnt_r + BIT_ONE;
            end
          end
        end
        PARITY: begin
          cnt_r <= cnt_next_s;
          if (sample_s) begin
            par_bit_r <= rx_s;
            bit_cnt_r <= BIT_ZERO;
            state_r   <= STOP;
          end
        end
        STOP: begin
          cnt_r <= cnt_next_s;
          if (sample_s) begin
            if (bit_cnt_r == LAST_STOP) begin
              // Leave mid stop bit so a start bit on the next boundary is seen.
              Dout       <= shift_r;
              parity_err <= par_en_r ? parity_error(shift_r, par_bit_r, par_odd_r) : 1'b0;
              frame_err  <= ferr_acc_r | ~rx_s;
              Dvalid     <= 1'b1;
              state_r    <= IDLE;
              busy       <= 1'b0;
              bit_cnt_r  <= BIT_ZERO;
            end else begin
              ferr_acc_r <= ferr_acc_r | ~rx_s;
              bit_cnt_r  <= bit_cnt_r + BIT_ONE;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          cnt_r   <= CNT_ZERO;
        end
      endcase
    end
  end

endmodule
